// File: rtl/rc4_prga_decrypt.sv
// ---------------------------------------------------------------------------
// rc4_prga_decrypt
//
// RC4 keystream generator (PRGA) with XOR decryption. Sits after the KSA
// block: once started it owns the S RAM port, reads one ciphertext byte per
// message position from the ROM and writes the matching plaintext byte to
// the plaintext RAM. Single-issue, nine clocks per byte.
//
// Ports
//   clk               in   clock, all logic on posedge
//   reset             in   asynchronous, active-high; clears all state
//   start             in   level, sampled only in IDLE (tie to KSA finished)
//   s_ram_out         in   S RAM read data (sync read, one-cycle latency)
//   s_address         out  S RAM address
//   s_ram_in          out  S RAM write data
//   s_write_enable    out  S RAM write strobe
//   rom_out           in   ciphertext ROM data (sync read, one-cycle latency)
//   rom_address       out  ciphertext ROM address (= k)
//   dec_address       out  plaintext RAM address (= k)
//   dec_data          out  plaintext byte (= f ^ enc)
//   dec_write_enable  out  plaintext RAM write strobe
//   busy              out  high while a pass is in progress
//   done              out  sticky completion flag, cleared on the next start
// ---------------------------------------------------------------------------
module rc4_prga_decrypt #(
  parameter int RAM_WIDTH  = 8,
  parameter int MSG_LENGTH = 32,
  localparam int MSG_AW    = $clog2(MSG_LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RAM_WIDTH-1:0] s_ram_out,
  output logic [RAM_WIDTH-1:0] s_address,
  output logic [RAM_WIDTH-1:0] s_ram_in,
  output logic                 s_write_enable,
  input  logic [RAM_WIDTH-1:0] rom_out,
  output logic [MSG_AW-1:0]    rom_address,
  output logic [MSG_AW-1:0]    dec_address,
  output logic [RAM_WIDTH-1:0] dec_data,
  output logic                 dec_write_enable,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    WT_SI,
    RD_SJ,
    WT_SJ,
    WR_SI,
    WR_SJ,
    RD_F,
    WT_F,
    WR_DEC,
    DONE
  } state_t;

  localparam logic [MSG_AW-1:0]    K_LAST = MSG_AW'(MSG_LENGTH - 1);
  localparam logic [RAM_WIDTH-1:0] ONE    = RAM_WIDTH'(1);

  state_t               state;
  logic [RAM_WIDTH-1:0] i;
  logic [RAM_WIDTH-1:0] j;
  logic [RAM_WIDTH-1:0] si;
  logic [RAM_WIDTH-1:0] sj;
  logic [RAM_WIDTH-1:0] f;
  logic [RAM_WIDTH-1:0] enc;
  logic [MSG_AW-1:0]    k;

  // k only changes at the end of WR_DEC, so it is already the right address
  // for the ROM read in RD_SI and the plaintext write in WR_DEC.
  assign rom_address = k;
  assign dec_address = k;
  // f and enc are both registered, so this is stable throughout WR_DEC.
  assign dec_data    = f ^ enc;

  // The S RAM address, write data and strobes are registered: each state
  // loads the values the *next* state must present, so they are valid for
  // the whole cycle of the state that owns them. Sums truncate to RAM_WIDTH,
  // which gives the modulo-256 wrap of i, j and si+sj for free.
  // NOTE: every register here uses <= so all right-hand sides see the values
  // from before the clock edge (e.g. WT_SI reads the old j to form the new j).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      i                <= '0;
      j                <= '0;
      k                <= '0;
      si               <= '0;
      sj               <= '0;
      f                <= '0;
      enc              <= '0;
      s_address        <= '0;
      s_ram_in         <= '0;
      s_write_enable   <= 1'b0;
      dec_write_enable <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      s_write_enable   <= 1'b0;
      dec_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i         <= ONE;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            s_address <= ONE;
            state     <= RD_SI;
          end
        end
        RD_SI: state <= WT_SI;
        WT_SI: begin
          si        <= s_ram_out;
          j         <= j + s_ram_out;
          enc       <= rom_out;
          s_address <= j + s_ram_out;
          state     <= RD_SJ;
        end
        RD_SJ: state <= WT_SJ;
        WT_SJ: begin
          // sj is captured on this same edge, so forward the read data
          // straight into the first swap write.
          sj             <= s_ram_out;
          s_address      <= i;
          s_ram_in       <= s_ram_out;
          s_write_enable <= 1'b1;
          state          <= WR_SI;
        end
        WR_SI: begin
          s_address      <= j;
          s_ram_in       <= si;
          s_write_enable <= 1'b1;
          state          <= WR_SJ;
        end
        WR_SJ: begin
          // The keystream read follows both swap writes, so it sees post-swap S.
          s_address <= si + sj;
          state     <= RD_F;
        end
        RD_F: state <= WT_F;
        WT_F: begin
          f                <= s_ram_out;
          dec_write_enable <= 1'b1;
          state            <= WR_DEC;
        end
        WR_DEC: begin
          if (k == K_LAST) begin
            state <= DONE;
          end else begin
            k         <= k + 1'b1;
            i         <= i + ONE;
            s_address <= i + ONE;
            state     <= RD_SI;
          end
        end
        DONE: begin
          // busy drops together with done rising, one cycle after DONE.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
